data_sync_hs: RTL and testbench
===============================

// Module: data_sync_hs
// PURPOSE
//  Destination-domain synchronizer for a quasi-static multi-bit bus qualified by an async level enable.
//  - Syncs BUS_EN through a NUM_STAGES flop chain and detects its rising edge on-chip.
//  - Captures UNSYNC_BUS once per enable edge into a small FIFO.
//  - Presents captured words downstream with a valid/ready handshake.
//  - Sits between the async source (e.g. UART RX) and destination-domain consumers (e.g. system controller).
// PARAMETERS
//  BUS_WIDTH   8   width of data bus
//  NUM_STAGES  2   synchronizer depth for BUS_EN (legal >= 2)
//  DEPTH       2   holding FIFO entries (power of 2, >= 2)
// PORTS
//  CLK         in   1          destination clock
//  RST         in   1          async active-low reset
//  UNSYNC_BUS  in   BUS_WIDTH  source data; held stable by source while BUS_EN high
//  BUS_EN      in   1          async level enable; one rising edge = one word
//  SYNC_BUS    out  BUS_WIDTH  head-of-FIFO data, valid when SYNC_VALID=1
//  SYNC_VALID  out  1          FIFO not empty
//  SYNC_READY  in   1          consumer accepts head word when SYNC_VALID & SYNC_READY
//  OVERFLOW    out  1          sticky: a capture was dropped because FIFO full
//  CLR_OVF     in   1          synchronous clear of OVERFLOW (and DROP_CNT)
// BEHAVIOUR
//  - Reset (RST=0, async): sync chain, edge reg, pointers, storage, OVERFLOW all 0 → SYNC_VALID=0, SYNC_BUS=0.
//  - Sync: en_sync = last stage of chain; en_sync_d = en_sync delayed 1 clk; cap = en_sync & ~en_sync_d.
//  - Latency: BUS_EN high sampled at edge k → cap high during cycle after edge k+NUM_STAGES-1.
//    Word written at edge k+NUM_STAGES; SYNC_VALID=1 after that edge if FIFO was empty (no bypass).
//  - BUS_EN held high: exactly one capture. Must fall and rise again for the next word.
//  - FIFO uses wr_ptr/rd_ptr with one extra wrap bit.
//    Empty: ptrs equal. Full: MSBs differ, rest equal. Pointers wrap modulo 2*DEPTH.
//  - pop = SYNC_VALID & SYNC_READY; rd_ptr increments at the edge.
//  - SYNC_BUS = mem[rd_ptr]; stable while SYNC_VALID & ~SYNC_READY.
//  - push = cap & (~full | pop): a full FIFO with a same-cycle pop still accepts the capture.
//  - cap & full & ~pop: word dropped, storage unchanged, OVERFLOW set at edge.
//  - CLR_OVF & overflow-event same cycle: set wins (OVERFLOW stays 1).
//  - Simultaneous push & pop on empty: impossible (pop needs SYNC_VALID). Push lands, valid next cycle.
//  - Reset mid-operation: FIFO contents discarded.
//    If BUS_EN is still high after reset release, it counts as a fresh edge (chain resets to 0) → one capture.
//  - Source contract: UNSYNC_BUS stable from before BUS_EN rise until after BUS_EN fall.
//    Bus is sampled directly at capture, not synchronized.
// CONFIGURATION
//  - Macro DSYNC_STATS_EN defined: adds output DROP_CNT [7:0].
//    Increments on each dropped capture, saturates at 8'hFF, reset 0, cleared by CLR_OVF (increment wins if same cycle).
//  - Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package data_sync_pkg: default widths/depth localparams; function clog2-based PTR_W(DEPTH).
//  - Package also holds a typedef for the FIFO pointer struct.
//  - Sub-module bit_sync (NUM_STAGES flop chain, 1-bit, async active-low reset), instantiated for BUS_EN.
//  - Edge detect, FIFO and overflow logic inline.
// TESTING
//  1. Reset: assert RST=0 with BUS_EN=1 → SYNC_VALID=0, SYNC_BUS=0, OVERFLOW=0.
//     Release → one capture, SYNC_VALID=1 after NUM_STAGES+1 edges.
//  2. Single word: UNSYNC_BUS=8'hA5, BUS_EN pulse of 5 clk, SYNC_READY=0.
//     → SYNC_VALID=1 at edge 3 (N=2), SYNC_BUS=8'hA5 held; READY=1 one cycle → VALID=0.
//  3. Hold-high: BUS_EN high 20 clk with bus 8'h3C → exactly one word queued.
//  4. Overflow: READY=0, three enable edges 8'h01/02/03 (DEPTH=2).
//     → FIFO holds 01,02; OVERFLOW=1; DROP_CNT=1 (STATS_EN); drain yields 01 then 02; CLR_OVF → 0.
//  5. Full + pop same cycle as capture 8'h04 → no drop; drain order 02,04 after 01 popped.
//  6. Random async BUS_EN timing vs CLK, random READY → scoreboard order preserved, no duplicates, no loss unless OVERFLOW.

Source files
------------

// File: rtl/data_sync_hs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : data_sync_pkg                                              |
// | Purpose : Shared defaults, FIFO pointer type and pointer helpers     |
// |           for the data_sync_hs destination-domain synchronizer.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package data_sync_pkg;

  localparam int DEFAULT_BUS_WIDTH  = 8;
  localparam int DEFAULT_NUM_STAGES = 2;
  localparam int DEFAULT_DEPTH      = 2;

  // Pointer index field is sized for the largest supported FIFO (256 entries);
  // only the low ptr_w(DEPTH)-1 bits are used to address storage.
  localparam int MAX_IDX_W = 8;

  // FIFO pointer: storage index plus one wrap bit that distinguishes full
  // from empty when the indices are equal.
  typedef struct packed {
    logic                 wrap;
    logic [MAX_IDX_W-1:0] idx;
  } fifo_ptr_t;

  // Pointer width (index bits + wrap bit) for a given FIFO depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Advance a pointer by one entry, toggling the wrap bit on index rollover,
  // so the pointer as a whole counts modulo 2*depth.
  function automatic fifo_ptr_t ptr_inc(input fifo_ptr_t p, input int depth);
    fifo_ptr_t r;
    r = p;
    if (p.idx == MAX_IDX_W'(depth - 1)) begin
      r.idx  = '0;
      r.wrap = ~p.wrap;
    end else begin
      r.idx = p.idx + MAX_IDX_W'(1);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sync_hs_bit_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bit_sync                                                   |
// | Purpose : NUM_STAGES-deep flop chain bringing one async level into   |
// |           the clk domain. NUM_STAGES must be at least 2.             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  // Shift the async input one stage further down the chain each clock.
  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], d};
  end

  // Chain register; clears to 0 so a level still high after reset is seen as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[NUM_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/data_sync_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : data_sync_hs                                               |
// | Purpose : Synchronizes BUS_EN, captures UNSYNC_BUS once per enable   |
// |           rising edge into a small FIFO and presents the words with  |
// |           a valid/ready handshake. Sticky OVERFLOW on dropped words. |
// | Config  : define DSYNC_STATS_EN to add the DROP_CNT[7:0] output.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module data_sync_hs
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_EN,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 SYNC_VALID,
  input  logic                 SYNC_READY,
  output logic                 OVERFLOW,
  input  logic                 CLR_OVF
`ifdef DSYNC_STATS_EN
  ,
  output logic [7:0]           DROP_CNT
`endif
);

  // Storage address bits; DEPTH is a power of two no larger than 256.
  localparam int IDX_W = ptr_w(DEPTH) - 1;

  logic en_sync;
  logic en_dly_q;
  logic en_dly_d;
  logic cap;

  fifo_ptr_t wr_q;
  fifo_ptr_t wr_d;
  fifo_ptr_t rd_q;
  fifo_ptr_t rd_d;

  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [BUS_WIDTH-1:0] mem_d [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  logic overflow_q;
  logic overflow_d;

  bit_sync #(
    .NUM_STAGES (NUM_STAGES)
  ) u_en_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (BUS_EN),
    .q     (en_sync)
  );

  // Rising-edge detect on the synchronized enable and FIFO handshake decode.
  always_comb begin
    en_dly_d = en_sync;
    cap      = en_sync & ~en_dly_q;
    empty    = (wr_q == rd_q);
    full     = (wr_q.wrap != rd_q.wrap) && (wr_q.idx == rd_q.idx);
    pop      = ~empty & SYNC_READY;
    // A full FIFO being popped this cycle frees the slot the capture lands in.
    push     = cap & (~full | pop);
    drop     = cap & full & ~pop;
  end

  // FIFO write/read pointer advance and storage update.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q.idx[IDX_W-1:0]] = UNSYNC_BUS;
      wr_d = ptr_inc(wr_q, DEPTH);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q, DEPTH);
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    overflow_d = overflow_q;
    if (CLR_OVF) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // State registers: edge-detect delay, pointers, storage and overflow flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_dly_q   <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      mem_q      <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      en_dly_q   <= en_dly_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
      overflow_q <= overflow_d;
    end
  end

  assign SYNC_BUS   = mem_q[rd_q.idx[IDX_W-1:0]];
  assign SYNC_VALID = ~empty;
  assign OVERFLOW   = overflow_q;

`ifdef DSYNC_STATS_EN
  logic [7:0] drop_cnt_q;
  logic [7:0] drop_cnt_d;

  // Saturating drop counter; a drop in the same cycle as a clear still counts.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      drop_cnt_d = (drop_cnt_q == 8'hFF) ? 8'hFF : drop_cnt_q + 8'd1;
    end else if (CLR_OVF) begin
      drop_cnt_d = 8'h00;
    end
  end

  // Drop counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_sync_hs.sv
`default_nettype none
`timescale 1ns/100ps
// +----------------------------------------------------------------------+
// | Module  : tb_data_sync_hs                                            |
// | Purpose : Self-checking bench for data_sync_hs (BUS_WIDTH=8,         |
// |           NUM_STAGES=2, DEPTH=2). DROP_CNT is checked when           |
// |           DSYNC_STATS_EN is defined.                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_data_sync_hs;

  logic       clk;
  logic       rst;
  logic [7:0] unsync_bus;
  logic       bus_en;
  logic [7:0] sync_bus;
  logic       sync_valid;
  logic       sync_ready;
  logic       overflow;
  logic       clr_ovf;
`ifdef DSYNC_STATS_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  data_sync_hs #(
    .BUS_WIDTH  (8),
    .NUM_STAGES (2),
    .DEPTH      (2)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .UNSYNC_BUS (unsync_bus),
    .BUS_EN     (bus_en),
    .SYNC_BUS   (sync_bus),
    .SYNC_VALID (sync_valid),
    .SYNC_READY (sync_ready),
    .OVERFLOW   (overflow),
    .CLR_OVF    (clr_ovf)
`ifdef DSYNC_STATS_EN
    ,
    .DROP_CNT   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One vector = inputs applied before a rising edge + outputs expected after it.
  typedef struct {
    logic       en;
    logic [7:0] bus;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] eb;
    logic       eo;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic en, input logic [7:0] bus, input logic rdy, input logic clr,
                     input logic ev, input logic [7:0] eb, input logic eo, input logic [7:0] ed);
    vec_t v;
    v.en = en; v.bus = bus; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.eb = eb;   v.eo = eo;   v.ed = ed;
    vecs.push_back(v);
  endtask

  // One enable pulse carrying word w: bus set a cycle early, 3 cycles high, 2 low.
  // The capture lands at the 4th edge; rdy3/clr3 are driven only for that edge.
  task automatic word(input logic [7:0] w, input logic rdy3, input logic clr3,
                      input logic v0, input logic [7:0] h0, input logic o0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] h1, input logic o1, input logic [7:0] d1);
    row(1'b0, w, 1'b0, 1'b0, v0, h0, o0, d0);
    row(1'b1, w, 1'b0, 1'b0, v0, h0, o0, d0);
    row(1'b1, w, 1'b0, 1'b0, v0, h0, o0, d0);
    row(1'b1, w, rdy3, clr3, v1, h1, o1, d1);
    row(1'b0, w, 1'b0, 1'b0, v1, h1, o1, d1);
    row(1'b0, w, 1'b0, 1'b0, v1, h1, o1, d1);
  endtask

  logic [7:0] exp_q[$];
  bit         prod_done;
  int         n_pops;
  bit         saw_ovf;

  initial begin
    rst        = 1'b0;
    bus_en     = 1'b1;
    unsync_bus = 8'h5A;
    sync_ready = 1'b0;
    clr_ovf    = 1'b0;
    prod_done  = 1'b0;
    n_pops     = 0;
    saw_ovf    = 1'b0;

    // ---- Test 1: reset with BUS_EN high, then a single capture after release
    repeat (3) @(negedge clk);
    chk("rst_valid", sync_valid, 0);
    chk("rst_bus", sync_bus, 8'h00);
    chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    @(posedge clk); #1 chk("rel_edge1_valid", sync_valid, 0);
    @(posedge clk); #1 chk("rel_edge2_valid", sync_valid, 0);
    @(posedge clk); #1 chk("rel_edge3_valid", sync_valid, 1);
    chk("rel_edge3_bus", sync_bus, 8'h5A);
    @(negedge clk);
    bus_en     = 1'b0;
    sync_ready = 1'b1;
    @(posedge clk); #1 chk("rel_pop_valid", sync_valid, 0);
    @(negedge clk);
    sync_ready = 1'b0;
    repeat (4) @(negedge clk);

    // ---- Test 2: single 5-clock pulse of A5, held until one-cycle READY
    row(1, 8'hA5, 0, 0, 0, 8'h00, 0, 0);
    row(1, 8'hA5, 0, 0, 0, 8'h00, 0, 0);
    row(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0);
    row(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0);
    row(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0);
    row(0, 8'hA5, 0, 0, 1, 8'hA5, 0, 0);
    row(0, 8'hA5, 1, 0, 0, 8'h00, 0, 0);
    row(0, 8'hA5, 0, 0, 0, 8'h00, 0, 0);

    // ---- Test 3: BUS_EN held high 20 clocks -> exactly one word
    for (int i = 0; i < 20; i++) begin
      row(1, 8'h3C, 0, 0, (i >= 2), 8'h3C, 0, 0);
    end
    row(0, 8'h3C, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      row(0, 8'h3C, 0, 0, 0, 8'h00, 0, 0);
    end

    // ---- Test 4: three words into a 2-deep FIFO, no READY -> third dropped
    word(8'h01, 0, 0, 0, 8'h00, 0, 0, 1, 8'h01, 0, 0);
    word(8'h02, 0, 0, 1, 8'h01, 0, 0, 1, 8'h01, 0, 0);
    word(8'h03, 0, 0, 1, 8'h01, 0, 0, 1, 8'h01, 1, 1);
    row(0, 8'h03, 1, 0, 1, 8'h02, 1, 1);
    row(0, 8'h03, 1, 0, 0, 8'h00, 1, 1);
    row(0, 8'h03, 0, 0, 0, 8'h00, 1, 1);
    row(0, 8'h03, 0, 1, 0, 8'h00, 0, 0);
    row(0, 8'h03, 0, 0, 0, 8'h00, 0, 0);

    // ---- Test 5: full FIFO popped in the same cycle as the capture of 04
    word(8'h01, 0, 0, 0, 8'h00, 0, 0, 1, 8'h01, 0, 0);
    word(8'h02, 0, 0, 1, 8'h01, 0, 0, 1, 8'h01, 0, 0);
    word(8'h04, 1, 0, 1, 8'h01, 0, 0, 1, 8'h02, 0, 0);
    row(0, 8'h04, 1, 0, 1, 8'h04, 0, 0);
    row(0, 8'h04, 1, 0, 0, 8'h00, 0, 0);
    row(0, 8'h04, 0, 0, 0, 8'h00, 0, 0);

    // ---- Test 7: drop coinciding with CLR_OVF -> set wins
    word(8'h11, 0, 0, 0, 8'h00, 0, 0, 1, 8'h11, 0, 0);
    word(8'h22, 0, 0, 1, 8'h11, 0, 0, 1, 8'h11, 0, 0);
    word(8'h33, 0, 1, 1, 8'h11, 0, 0, 1, 8'h11, 1, 1);
    row(0, 8'h33, 1, 1, 1, 8'h22, 0, 0);
    row(0, 8'h33, 1, 0, 0, 8'h00, 0, 0);
    row(0, 8'h33, 0, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus_en     = vecs[i].en;
      unsync_bus = vecs[i].bus;
      sync_ready = vecs[i].rdy;
      clr_ovf    = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), sync_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("vec%0d_bus", i), sync_bus, vecs[i].eb);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].eo);
`ifdef DSYNC_STATS_EN
      chk($sformatf("vec%0d_dropcnt", i), drop_cnt, vecs[i].ed);
`endif
    end

    // ---- Test 6: random async BUS_EN timing, random READY, scoreboard
    @(negedge clk);
    bus_en     = 1'b0;
    sync_ready = 1'b0;
    clr_ovf    = 1'b1;
    @(negedge clk);
    clr_ovf    = 1'b0;
    fork
      begin : producer
        for (int w = 0; w < 30; w++) begin
          #($urandom_range(2, 9));
          unsync_bus = 8'(8'h40 + w);
          #($urandom_range(3, 12));
          #0.3;
          bus_en = 1'b1;
          exp_q.push_back(8'(8'h40 + w));
          #($urandom_range(30, 70));
          bus_en = 1'b0;
          #($urandom_range(25, 60));
        end
        prod_done = 1'b1;
      end
      begin : consumer
        int cyc;
        int tail;
        cyc  = 0;
        tail = 0;
        while (tail < 40) begin
          @(negedge clk);
          sync_ready = ($urandom_range(0, 3) != 0);
          if (overflow) saw_ovf = 1'b1;
          if (sync_valid && sync_ready) begin
            // Words lost to a recorded overflow may be skipped, nothing else.
            while (saw_ovf && exp_q.size() > 0 && exp_q[0] != sync_bus) void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
              chk("rnd_unexpected_word", sync_bus, 32'hFFFF_FFFF);
            end else begin
              chk($sformatf("rnd_pop%0d", n_pops), sync_bus, exp_q.pop_front());
            end
            n_pops++;
          end
          cyc++;
          if (prod_done) tail++;
          if (cyc > 20000) begin
            chk("rnd_timeout", cyc, 0);
            tail = 40;
          end
        end
      end
    join
    sync_ready = 1'b0;
    chk("rnd_drained_valid", sync_valid, 0);
    if (!saw_ovf) begin
      chk("rnd_leftover", exp_q.size(), 0);
      chk("rnd_pop_count", n_pops, 30);
    end

    // ---- Reset mid-operation discards the FIFO
    @(negedge clk);
    unsync_bus = 8'h77;
    bus_en     = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_valid_before_rst", sync_valid, 1);
    chk("mid_bus_before_rst", sync_bus, 8'h77);
    rst    = 1'b0;
    bus_en = 1'b0;
    #1;
    chk("mid_rst_valid", sync_valid, 0);
    chk("mid_rst_bus", sync_bus, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_post_rst_valid", sync_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
